// File: rtl/micro_processor_if.sv
// micro_processor external bus: data input/output plus the instruction-memory loader.
// "master" is the processor side, "slave" is the surrounding system / loader side.
interface micro_processor_if #(
    parameter int IMEM_DEPTH = 16
);
    localparam int PCW = $clog2(IMEM_DEPTH);

    logic [15:0]    din;
    logic [15:0]    dout;
    logic           imem_we;
    logic [PCW-1:0] imem_addr;
    logic [31:0]    imem_wdata;

    modport master (
        input  din,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        output dout
    );

    modport slave (
        output din,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        input  dout
    );
endinterface

// File: rtl/micro_processor.sv
// micro_processor: 16-bit multi-cycle register machine (FETCH, EXEC, DELAY x DLY_CYCLES, NEXT).
// 32 GPRs, SGPR for the multiply high half, sign/zero/carry/overflow flags.
// Optional feature macro: MUL_EN -- when defined, opcode 4 multiplies; otherwise it is a NOP.
module micro_processor #(
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16,
    parameter int DLY_CYCLES = 4
) (
    input  logic               clk,
    input  logic               sys_rst,
    micro_processor_if.master  io
);
    localparam int PCW = $clog2(IMEM_DEPTH);
    localparam int DW  = $clog2(DMEM_DEPTH);
    localparam logic [7:0]     DLY_LAST = 8'((DLY_CYCLES > 0) ? DLY_CYCLES - 1 : 0);
    localparam logic [PCW-1:0] PC_LAST  = PCW'(IMEM_DEPTH - 1);

    typedef enum logic [2:0] {FETCH, EXEC, DELAY, NEXT, HALT} state_t;

    state_t         state;
    logic [7:0]     count;
    logic [PCW-1:0] pc;
    logic [31:0]    ir;
    logic [15:0]    gpr [32];
    logic [15:0]    sgpr;
    logic           sign_f, zero_f, carry_f, ovf_f;
    logic           stop, jmp_flag;
    logic [15:0]    dout_q;
    logic [31:0]    inst_mem [IMEM_DEPTH];
    logic [15:0]    data_mem [DMEM_DEPTH];

    // instruction field decode
    logic [4:0]     op, rdst, rsrc1, rsrc2;
    logic           imm_mode;
    logic [15:0]    imm, opa, opb, dm_rd;
    logic [DW-1:0]  dm_idx;

    assign op       = ir[31:27];
    assign rdst     = ir[26:22];
    assign rsrc1    = ir[21:17];
    assign imm_mode = ir[16];
    assign rsrc2    = ir[15:11];
    assign imm      = ir[15:0];
    assign opa      = gpr[rsrc1];
    assign opb      = imm_mode ? imm : gpr[rsrc2];
    assign dm_idx   = imm[DW-1:0];
    assign dm_rd    = data_mem[dm_idx];
    assign io.dout  = dout_q;

    logic [15:0] res;
    logic        res_c, res_v, upd, jmp_take;
    logic [16:0] sum17, dif17;
    logic [31:0] rot32;
`ifdef MUL_EN
    logic [31:0] prod;
`endif

    // ALU result, flag candidates and jump condition for the instruction in IR
    always_comb begin
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        upd      = 1'b0;
        jmp_take = 1'b0;
        sum17    = {1'b0, opa} + {1'b0, opb};
        dif17    = {1'b0, opa} - {1'b0, opb};
        rot32    = {opa, opa} >> opb[3:0];
`ifdef MUL_EN
        prod     = 32'(opa) * 32'(opb);
`endif
        case (op)
            5'd2:  begin res = sum17[15:0]; res_c = sum17[16];
                         res_v = (opa[15] == opb[15]) && (res[15] != opa[15]); upd = 1'b1; end
            5'd3:  begin res = dif17[15:0]; res_c = dif17[16];
                         res_v = (opa[15] != opb[15]) && (res[15] != opa[15]); upd = 1'b1; end
`ifdef MUL_EN
            5'd4:  begin res = prod[15:0]; upd = 1'b1; end
`endif
            5'd5:  begin res = rot32[15:0];      upd = 1'b1; end
            5'd6:  begin res = opa & opb;        upd = 1'b1; end
            5'd7:  begin res = opa ^ opb;        upd = 1'b1; end
            5'd8:  begin res = ~(opa ^ opb);     upd = 1'b1; end
            5'd9:  begin res = ~(opa & opb);     upd = 1'b1; end
            5'd10: begin res = ~(opa | opb);     upd = 1'b1; end
            5'd11: begin res = ~opb;             upd = 1'b1; end
            5'd17: jmp_take = 1'b1;
            5'd18: jmp_take = carry_f;
            5'd19: jmp_take = !carry_f;
            5'd20: jmp_take = sign_f;
            5'd21: jmp_take = !sign_f;
            5'd22: jmp_take = zero_f;
            5'd23: jmp_take = !zero_f;
            5'd24: jmp_take = ovf_f;
            5'd25: jmp_take = !ovf_f;
            default: ;
        endcase
    end

    // sequencer and architectural state; memories are deliberately outside reset
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state    <= FETCH;
            count    <= '0;
            pc       <= '0;
            ir       <= '0;
            sgpr     <= '0;
            sign_f   <= 1'b0;
            zero_f   <= 1'b0;
            carry_f  <= 1'b0;
            ovf_f    <= 1'b0;
            stop     <= 1'b0;
            jmp_flag <= 1'b0;
            dout_q   <= '0;
            for (int unsigned i = 0; i < 32; i++) gpr[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= inst_mem[pc];
                    state <= EXEC;
                end
                EXEC: begin
                    if (upd) begin
                        gpr[rdst] <= res;
                        zero_f    <= (res == '0);
                        sign_f    <= res[15];
                        carry_f   <= res_c;
                        ovf_f     <= res_v;
                    end
                    case (op)
                        5'd0:  gpr[rdst] <= sgpr;
                        5'd1:  gpr[rdst] <= opb;
`ifdef MUL_EN
                        5'd4:  sgpr      <= prod[31:16];
`endif
                        5'd15: dout_q    <= dm_rd;
                        5'd16: gpr[rdst] <= dm_rd;
                        5'd26: stop      <= 1'b1;
                        default: ;
                    endcase
                    jmp_flag <= jmp_take;
                    count    <= '0;
                    state    <= (DLY_CYCLES == 0) ? NEXT : DELAY;
                end
                DELAY: begin
                    if (count == DLY_LAST) state <= NEXT;
                    else count <= count + 8'd1;
                end
                NEXT: begin
                    if (stop) begin
                        state <= HALT;
                    end else begin
                        if (jmp_flag)          pc <= imm[PCW-1:0];
                        else if (pc == PC_LAST) pc <= '0;
                        else                    pc <= pc + 1'b1;
                        state <= FETCH;
                    end
                    jmp_flag <= 1'b0;
                end
                HALT: ;
                default: state <= FETCH;
            endcase
        end
    end

    // instruction loader and data-memory stores
    always_ff @(posedge clk) begin
        if (io.imem_we) inst_mem[io.imem_addr] <= io.imem_wdata;
        if (state == EXEC && op == 5'd13) data_mem[dm_idx] <= opa;
        if (state == EXEC && op == 5'd14) data_mem[dm_idx] <= io.din;
    end
endmodule

// File: tb/tb_micro_processor.sv
// Self-checking bench for micro_processor: instruction-level model plus per-cycle compare.
module tb_micro_processor;
    localparam int INSN_CYC = 7;
    localparam int MAXC     = 127;

    logic clk = 1'b0;
    logic sys_rst;
    always #5 clk = ~clk;

    micro_processor_if #(.IMEM_DEPTH(16)) io ();
    micro_processor #(.IMEM_DEPTH(16), .DMEM_DEPTH(16), .DLY_CYCLES(4)) dut (
        .clk(clk), .sys_rst(sys_rst), .io(io)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // program and per-cycle expectations
    logic [31:0] prog [16];
    logic [15:0] exp_dout [MAXC+1];
    logic [3:0]  exp_pc   [MAXC+1];
    logic [3:0]  exp_flg  [MAXC+1];

    // instruction-level model state
    logic [15:0] m_gpr [32];
    logic [15:0] m_dmem [16];
    logic [15:0] m_sgpr, m_dout;
    bit m_s, m_z, m_c, m_v, m_jmp, m_stop, m_halt;
    int m_pc, m_tgt;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic im,
                                        input logic [15:0] imm16);
        return {op, rd, rs1, im, imm16};
    endfunction

    task automatic m_exec(input logic [31:0] ins, input logic [15:0] din_v);
        int op, rd, rs1, a, b, r, sa, sb, ss, idx;
        bit im, upd, nc, nv;
        logic [15:0] imm16;
`ifdef MUL_EN
        longint p;
`endif
        op = int'(ins[31:27]); rd = int'(ins[26:22]); rs1 = int'(ins[21:17]);
        im = ins[16]; imm16 = ins[15:0];
        a = int'(m_gpr[rs1]);
        b = im ? int'(imm16) : int'(m_gpr[ins[15:11]]);
        sa = (a > 32767) ? a - 65536 : a;
        sb = (b > 32767) ? b - 65536 : b;
        idx = int'(imm16) % 16;
        m_tgt = int'(imm16) % 16;
        upd = 0; nc = 0; nv = 0; r = 0;
        case (op)
            0:  m_gpr[rd] = m_sgpr;
            1:  m_gpr[rd] = 16'(b);
            2:  begin r = a + b; nc = (r > 65535); ss = sa + sb;
                      nv = (ss > 32767) || (ss < -32768); r = r % 65536; upd = 1; end
            3:  begin nc = (a < b); r = (a - b + 65536) % 65536; ss = sa - sb;
                      nv = (ss > 32767) || (ss < -32768); upd = 1; end
`ifdef MUL_EN
            4:  begin p = longint'(a) * longint'(b); r = int'(p % 65536);
                      m_sgpr = 16'(p / 65536); upd = 1; end
`endif
            5:  begin r = a; for (int k = 0; k < b % 16; k++) r = (r >> 1) | ((r % 2) << 15); upd = 1; end
            6:  begin r = a & b;                upd = 1; end
            7:  begin r = a ^ b;                upd = 1; end
            8:  begin r = (~(a ^ b)) & 65535;   upd = 1; end
            9:  begin r = (~(a & b)) & 65535;   upd = 1; end
            10: begin r = (~(a | b)) & 65535;   upd = 1; end
            11: begin r = (~b) & 65535;         upd = 1; end
            13: m_dmem[idx] = m_gpr[rs1];
            14: m_dmem[idx] = din_v;
            15: m_dout = m_dmem[idx];
            16: m_gpr[rd] = m_dmem[idx];
            17: m_jmp = 1;
            18: m_jmp = m_c;
            19: m_jmp = !m_c;
            20: m_jmp = m_s;
            21: m_jmp = !m_s;
            22: m_jmp = m_z;
            23: m_jmp = !m_z;
            24: m_jmp = m_v;
            25: m_jmp = !m_v;
            26: m_stop = 1;
            default: ;
        endcase
        if (upd) begin
            m_gpr[rd] = 16'(r);
            m_z = (r == 0); m_s = (r > 32767); m_c = nc; m_v = nv;
        end
    endtask

    task automatic m_record(input int e);
        exp_dout[e] = m_dout;
        exp_pc[e]   = 4'(m_pc);
        exp_flg[e]  = {m_s, m_z, m_c, m_v};
    endtask

    // each instruction: fetch edge, exec edge, 4 delay edges, next edge
    task automatic model_run(input int ncyc, input logic [15:0] din_v, input int force_after);
        m_pc = 0; m_sgpr = 0; m_dout = 0; m_tgt = 0;
        m_s = 0; m_z = 0; m_c = 0; m_v = 0; m_jmp = 0; m_stop = 0; m_halt = 0;
        for (int i = 0; i < 32; i++) m_gpr[i] = 0;
        m_record(0);
        for (int e = 1; e <= ncyc; e++) begin
            if (!m_halt) begin
                if (force_after > 0 && e > force_after) m_stop = 1;
                case ((e - 1) % INSN_CYC)
                    1: m_exec(prog[m_pc], din_v);
                    6: begin
                        if (m_stop) m_halt = 1;
                        else m_pc = m_jmp ? m_tgt : (m_pc + 1) % 16;
                        m_jmp = 0;
                    end
                    default: ;
                endcase
            end
            m_record(e);
        end
    endtask

    // per-cycle compare against the model
    int cyc;
    bit run, chk_en;
    always @(posedge clk) begin
        if (run) cyc <= cyc + 1;
        else     cyc <= 0;
    end

    always @(negedge clk) begin
        if (chk_en && cyc <= MAXC) begin
            check16("dout", io.dout, exp_dout[cyc]);
            check16("pc", {12'b0, dut.pc}, {12'b0, exp_pc[cyc]});
            check16("flags", {12'b0, dut.sign_f, dut.zero_f, dut.carry_f, dut.ovf_f},
                    {12'b0, exp_flg[cyc]});
        end
    end

    task automatic fill_halt();
        for (int i = 0; i < 16; i++) prog[i] = enc(5'd26, 5'd0, 5'd0, 1'b0, 16'h0);
    endtask

    task automatic run_prog(input int ncyc, input logic [15:0] din_v, input int force_after);
        sys_rst = 1'b0; run = 0; chk_en = 0; io.din = din_v;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            io.imem_we = 1'b1; io.imem_addr = 4'(i); io.imem_wdata = prog[i];
        end
        @(negedge clk);
        io.imem_we = 1'b0;
        model_run(ncyc, din_v, force_after);
        @(posedge clk);
        #2 sys_rst = 1'b1; run = 1; chk_en = 1;
        for (int e = 1; e <= ncyc; e++) begin
            @(posedge clk);
            if (e == force_after) begin
                #2 force dut.stop = 1'b1;
            end
        end
        @(negedge clk);
        #1 chk_en = 0; run = 0;
    endtask

    initial begin
        sys_rst = 1'b0; run = 0; chk_en = 0;
        io.din = '0; io.imem_we = 1'b0; io.imem_addr = '0; io.imem_wdata = '0;
        repeat (2) @(negedge clk);
        check16("rst_dout", io.dout, 16'h0000);
        check16("rst_pc", {12'b0, dut.pc}, 16'h0000);

        // A: MOV r0,#5; ADD r1,r0,#3; STOREREG r1->m2; SENDDOUT m2; HALT
        fill_halt();
        prog[0] = enc(5'd1,  5'd0, 5'd0, 1'b1, 16'd5);
        prog[1] = enc(5'd2,  5'd1, 5'd0, 1'b1, 16'd3);
        prog[2] = enc(5'd13, 5'd0, 5'd1, 1'b1, 16'd2);
        prog[3] = enc(5'd15, 5'd0, 5'd0, 1'b1, 16'd2);
        run_prog(40, 16'h0000, 0);
        check16("mdl_A_dout23", exp_dout[23], 16'h0008);
        check16("A_dout", io.dout, 16'h0008);
        check16("A_zero_sign", {14'b0, dut.zero_f, dut.sign_f}, 16'h0000);
        check16("A_pc", {12'b0, dut.pc}, 16'h0004);

        // B: STOREDIN m0; SENDDOUT m0; NOP; HALT at 3
        fill_halt();
        prog[0] = enc(5'd14, 5'd0, 5'd0, 1'b1, 16'd0);
        prog[1] = enc(5'd15, 5'd0, 5'd0, 1'b1, 16'd0);
        prog[2] = enc(5'd12, 5'd0, 5'd0, 1'b0, 16'd0);
        run_prog(40, 16'h5678, 0);
        check16("B_dout", io.dout, 16'h5678);
        io.din = 16'h9ABC;
        repeat (12) @(negedge clk);
        check16("B_dout_hold", io.dout, 16'h5678);
        check16("B_pc_frozen", {12'b0, dut.pc}, 16'h0003);

        // B again, interrupted mid-instruction by async reset
        run_prog(12, 16'h5678, 0);
        check16("R_pc_before", {12'b0, dut.pc}, 16'h0001);
        check16("R_dout_before", io.dout, 16'h5678);
        #2 sys_rst = 1'b0;
        #1;
        check16("R_dout_async", io.dout, 16'h0000);
        check16("R_pc_async", {12'b0, dut.pc}, 16'h0000);

        // C: carry/zero from FFFF+1, JZERO 9, then overflow from 7FFF+1
        fill_halt();
        prog[0]  = enc(5'd1,  5'd0, 5'd0, 1'b1, 16'hFFFF);
        prog[1]  = enc(5'd2,  5'd0, 5'd0, 1'b1, 16'd1);
        prog[2]  = enc(5'd22, 5'd0, 5'd0, 1'b1, 16'd9);
        prog[9]  = enc(5'd1,  5'd3, 5'd0, 1'b1, 16'h7FFF);
        prog[10] = enc(5'd2,  5'd4, 5'd3, 1'b1, 16'd1);
        prog[11] = enc(5'd13, 5'd0, 5'd4, 1'b1, 16'd1);
        prog[12] = enc(5'd15, 5'd0, 5'd0, 1'b1, 16'd1);
        run_prog(64, 16'h0000, 0);
        check16("mdl_C_flags_add", {12'b0, exp_flg[9]}, 16'h0006);
        check16("mdl_C_pc_jump", {12'b0, exp_pc[21]}, 16'h0009);
        check16("C_dout", io.dout, 16'h8000);
        check16("C_flags", {12'b0, dut.sign_f, dut.zero_f, dut.carry_f, dut.ovf_f}, 16'h0009);
        check16("C_pc", {12'b0, dut.pc}, 16'h000D);

        // D: MUL/MOVSGPR, ROR, SUB borrow, JCARRY, XNOR, SENDREG
        fill_halt();
        prog[0]  = enc(5'd1,  5'd0, 5'd0, 1'b1, 16'h1234);
        prog[1]  = enc(5'd4,  5'd1, 5'd0, 1'b1, 16'h0100);
        prog[2]  = enc(5'd0,  5'd2, 5'd0, 1'b0, 16'h0);
        prog[3]  = enc(5'd13, 5'd0, 5'd2, 1'b1, 16'd3);
        prog[4]  = enc(5'd15, 5'd0, 5'd0, 1'b1, 16'd3);
        prog[5]  = enc(5'd5,  5'd5, 5'd0, 1'b1, 16'd4);
        prog[6]  = enc(5'd3,  5'd6, 5'd5, 1'b1, 16'h5000);
        prog[7]  = enc(5'd18, 5'd0, 5'd0, 1'b1, 16'd9);
        prog[9]  = enc(5'd8,  5'd7, 5'd6, 1'b0, 16'h0000);
        prog[10] = enc(5'd13, 5'd0, 5'd7, 1'b1, 16'd4);
        prog[11] = enc(5'd15, 5'd0, 5'd0, 1'b1, 16'd4);
        prog[12] = enc(5'd16, 5'd8, 5'd0, 1'b1, 16'd4);
        run_prog(96, 16'h0000, 0);
        check16("D_dout", io.dout, 16'h1CE8);
        check16("D_pc", {12'b0, dut.pc}, 16'h000D);
        check16("D_r5_ror", dut.gpr[5], 16'h4123);
        check16("D_r6_sub", dut.gpr[6], 16'hF123);
        check16("D_r8_sendreg", dut.gpr[8], 16'h1CE8);
`ifdef MUL_EN
        check16("mdl_D_mul_dout", exp_dout[30], 16'h0012);
        check16("D_sgpr", dut.sgpr, 16'h0012);
        check16("D_r1_mul_lo", dut.gpr[1], 16'h3400);
        check16("D_r2_movsgpr", dut.gpr[2], 16'h0012);
`else
        check16("mdl_D_mul_dout", exp_dout[30], 16'h0000);
        check16("D_sgpr", dut.sgpr, 16'h0000);
        check16("D_r1_mul_nop", dut.gpr[1], 16'h0000);
        check16("D_r2_movsgpr", dut.gpr[2], 16'h0000);
`endif

        // E: endless loop halted by stop forced during instruction 1
        fill_halt();
        prog[0] = enc(5'd14, 5'd0, 5'd0, 1'b1, 16'd0);
        prog[1] = enc(5'd15, 5'd0, 5'd0, 1'b1, 16'd0);
        prog[2] = enc(5'd17, 5'd0, 5'd0, 1'b1, 16'd0);
        run_prog(40, 16'h00A5, 10);
        check16("mdl_E_pc", {12'b0, exp_pc[40]}, 16'h0001);
        check16("E_pc", {12'b0, dut.pc}, 16'h0001);
        check16("E_dout", io.dout, 16'h00A5);
        release dut.stop;
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
